oled_frame_scheduler: RTL and testbench

//  Shares the 96x64 OLED pixel-data stream between NUM_REQ drawing requesters.

---
 rtl/oled_frame_scheduler.sv | 102 ++++++++++
 tb/tb_oled_frame_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/oled_frame_scheduler.sv
// rtl/oled_frame_scheduler.sv - frame-granular round-robin owner of the OLED pixel stream
// Ownership only changes on the last-pixel strobe, so a frame is never split between requesters.
module oled_frame_scheduler #(
    parameter int          NUM_REQ    = 4,
    parameter int          MAX_FRAMES = 4,
    parameter logic [15:0] BG_COLOUR  = 16'h0000
) (
    input  logic                    clock_100mhz,
    input  logic                    reset_n,
    input  logic                    pixel_en,
    input  logic [6:0]              pixel_x,
    input  logic [5:0]              pixel_y,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   pixel_data_in,
    output logic [NUM_REQ-1:0]      grant,
    output logic [15:0]             pixel_data_out,
    output logic                    frame_start,
    output logic                    busy,
    output logic [7:0]              frame_count
);

    localparam int          IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]  CAP   = 8'(MAX_FRAMES - 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [7:0]         run_count;

    logic               frame_end;
    logic               others;
    logic               keep;
    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   pick;
    logic               pick_valid;
    int                 idx;

    assign frame_end = pixel_en && (pixel_x == 7'd95) && (pixel_y == 6'd63);
    assign others    = |(req & ~grant);
    assign keep      = (state == OWNED) && req[owner] && (!others || (run_count < CAP));

    // The current owner is excluded from the search when it still requests but hit its cap.
    always_comb begin
        cand       = req;
        pick       = rr_ptr;
        pick_valid = 1'b0;
        idx        = 0;
        if (state == OWNED && req[owner])
            cand = req & ~grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!pick_valid && cand[IDX_W'(idx)]) begin
                pick       = IDX_W'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        pixel_data_out = BG_COLOUR;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i])
                pixel_data_out = pixel_data_in[16*i +: 16];
    end

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
            run_count   <= 8'd0;
            grant       <= '0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            frame_start <= frame_end;
            if (frame_end) begin
                frame_count <= frame_count + 8'd1;
                if (keep) begin
                    if (run_count < CAP)
                        run_count <= run_count + 8'd1;
                end else if (pick_valid) begin
                    state     <= OWNED;
                    owner     <= pick;
                    rr_ptr    <= pick;
                    grant     <= NUM_REQ'(1) << pick;
                    busy      <= 1'b1;
                    run_count <= 8'd0;
                end else begin
                    state     <= IDLE;
                    grant     <= '0;
                    busy      <= 1'b0;
                    run_count <= 8'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_oled_frame_scheduler.sv
// tb/tb_oled_frame_scheduler.sv - directed-vector bench for oled_frame_scheduler
module tb_oled_frame_scheduler;

    logic        clock_100mhz = 1'b0;
    logic        reset_n;
    logic        pixel_en;
    logic [6:0]  pixel_x;
    logic [5:0]  pixel_y;
    logic [3:0]  req;
    logic [63:0] pixel_data_in;
    logic [3:0]  grant;
    logic [15:0] pixel_data_out;
    logic        frame_start;
    logic        busy;
    logic [7:0]  frame_count;

    int vectors   = 0;
    int miscompares = 0;
    int pulses    = 0;
    logic [7:0] exp_fc;
    logic [3:0] exp_owner [12];

    oled_frame_scheduler #(.NUM_REQ(4), .MAX_FRAMES(4), .BG_COLOUR(16'h0000)) dut (
        .clock_100mhz   (clock_100mhz),
        .reset_n        (reset_n),
        .pixel_en       (pixel_en),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .req            (req),
        .pixel_data_in  (pixel_data_in),
        .grant          (grant),
        .pixel_data_out (pixel_data_out),
        .frame_start    (frame_start),
        .busy           (busy),
        .frame_count    (frame_count)
    );

    always #5 clock_100mhz = ~clock_100mhz;

    always @(negedge clock_100mhz)
        if (frame_start === 1'b1)
            pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pixel strobe every 8 cycles; returns on the negedge after the sampling edge.
    task automatic strobe(input logic [6:0] x, input logic [5:0] y);
        repeat (6) @(negedge clock_100mhz);
        @(negedge clock_100mhz);
        pixel_en = 1'b1;
        pixel_x  = x;
        pixel_y  = y;
        @(negedge clock_100mhz);
        pixel_en = 1'b0;
    endtask

    task automatic end_frame();
        strobe(7'd95, 6'd63);
        exp_fc = exp_fc + 8'd1;
        check("frame_start_pulse", 32'(frame_start), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clock_100mhz);
        reset_n = 1'b0;
        @(negedge clock_100mhz);
        reset_n = 1'b1;
        exp_fc  = 8'd0;
    endtask

    initial begin
        reset_n       = 1'b0;
        pixel_en      = 1'b0;
        pixel_x       = 7'd0;
        pixel_y       = 6'd0;
        req           = 4'b0000;
        pixel_data_in = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
        exp_fc        = 8'd0;
        for (int k = 0; k < 12; k++)
            exp_owner[k] = 4'b0001 << (k / 4);

        #3;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        check("rst_frame_count", 32'(frame_count), 32'h0);
        check("rst_data", 32'(pixel_data_out), 32'h0);
        @(negedge clock_100mhz);
        reset_n = 1'b1;

        // Request mid-frame from IDLE: grant waits for the boundary.
        req = 4'b0100;
        strobe(7'd10, 6'd5);
        check("idle_req_no_grant", 32'(grant), 32'h0);
        strobe(7'd50, 6'd30);
        check("idle_req_no_grant2", 32'(grant), 32'h0);
        end_frame();
        check("first_grant", 32'(grant), 32'h4);
        check("first_busy", 32'(busy), 32'h1);
        check("first_data", 32'(pixel_data_out), 32'hC222);
        check("first_fc", 32'(frame_count), 32'(exp_fc));
        @(negedge clock_100mhz);
        check("frame_start_one_cycle", 32'(frame_start), 32'h0);

        // Sole requester holds indefinitely, then releases to IDLE.
        for (int f = 0; f < 10; f++) begin
            strobe(7'd20, 6'd40);
            check("sole_mid", 32'(grant), 32'h4);
            end_frame();
            check("sole_grant", 32'(grant), 32'h4);
        end
        req = 4'b0000;
        strobe(7'd5, 6'd5);
        check("drop_mid_keep", 32'(grant), 32'h4);
        end_frame();
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_data", 32'(pixel_data_out), 32'h0);
        check("idle_fc", 32'(frame_count), 32'(exp_fc));

        // Async reset mid-frame while requester 1 owns.
        req = 4'b0010;
        end_frame();
        check("own1_grant", 32'(grant), 32'h2);
        check("own1_data", 32'(pixel_data_out), 32'hB111);
        strobe(7'd20, 6'd20);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_fc", 32'(frame_count), 32'h0);
        check("async_rst_data", 32'(pixel_data_out), 32'h0);
        @(negedge clock_100mhz);
        reset_n = 1'b1;
        exp_fc  = 8'd0;

        // All requesting: round-robin with a 4-frame cap.
        req = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            end_frame();
            check("rr_owner", 32'(grant), 32'(exp_owner[k]));
            strobe(7'd30, 6'd10);
            check("rr_mid_hold", 32'(grant), 32'(exp_owner[k]));
        end

        // Owner 1 drops mid-frame while 3 waits.
        req = 4'b0010;
        end_frame();
        check("setup_own1", 32'(grant), 32'h2);
        req = 4'b1010;
        end_frame();
        check("own1_kept", 32'(grant), 32'h2);
        strobe(7'd39, 6'd30);
        req = 4'b1000;
        strobe(7'd40, 6'd30);
        check("drop_hold", 32'(grant), 32'h2);
        strobe(7'd95, 6'd62);
        check("drop_hold_row62", 32'(grant), 32'h2);
        end_frame();
        check("handover_3", 32'(grant), 32'h8);
        check("handover_data", 32'(pixel_data_out), 32'hD333);

        // 256 boundaries with out-of-range strobes between them.
        req = 4'b0000;
        do_reset();
        pulses = 0;
        for (int f = 0; f < 256; f++) begin
            strobe(7'd100, 6'd63);
            check("no_false_boundary", 32'(frame_start), 32'h0);
            end_frame();
            if (f == 254)
                check("fc_255", 32'(frame_count), 32'hFF);
        end
        check("fc_wrap", 32'(frame_count), 32'h0);
        check("fc_model", 32'(frame_count), 32'(exp_fc));
        @(negedge clock_100mhz);
        check("pulse_total", 32'(pulses), 32'd256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
